jtag_multichain_tap: RTL

Self-contained IEEE 1149.1 TAP with a built-in 16-state controller, an instruction register of `IR_W` bits, and `N_CHAINS` independently selectable internal scan chains. It is the parametrised successor of the single-chain TAP wrapper and sits between the chip JTAG pads and the scan-inserted core. Each chain gets its own shift enable. A shared `test` mode strap is driven to the core, and TDO is multiplexed across the IR, BYPASS, IDCODE and the selected chain.

---
 rtl/jtag_pkg.sv | 38 +++
 rtl/jtag_tap_fsm.sv | 41 ++++
 rtl/jtag_multichain_tap.sv | 136 +++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, IR capture pattern and opcode helper.
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_TLR      = 4'h0,
        ST_RTI      = 4'h1,
        ST_SEL_DR   = 4'h2,
        ST_CAP_DR   = 4'h3,
        ST_SHIFT_DR = 4'h4,
        ST_EXIT1_DR = 4'h5,
        ST_PAUSE_DR = 4'h6,
        ST_EXIT2_DR = 4'h7,
        ST_UPD_DR   = 4'h8,
        ST_SEL_IR   = 4'h9,
        ST_CAP_IR   = 4'hA,
        ST_SHIFT_IR = 4'hB,
        ST_EXIT1_IR = 4'hC,
        ST_PAUSE_IR = 4'hD,
        ST_EXIT2_IR = 4'hE,
        ST_UPD_IR   = 4'hF
    } tap_state_e;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

    typedef struct packed {
        logic [15:0] bypass;
        logic [15:0] idcode;
    } tap_ops_t;

    // BYPASS is all-ones, IDCODE is all-ones minus one, for any IR width.
    function automatic tap_ops_t tap_ops(input int unsigned ir_w);
        tap_ops_t o;
        o.bypass = 16'((32'd1 << ir_w) - 32'd1);
        o.idcode = 16'((32'd1 << ir_w) - 32'd2);
        return o;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller; state advances on posedge tck.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e r_state;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_state <= ST_TLR;
        end else begin
            case (r_state)
                ST_TLR:      r_state <= tms ? ST_TLR      : ST_RTI;
                ST_RTI:      r_state <= tms ? ST_SEL_DR   : ST_RTI;
                ST_SEL_DR:   r_state <= tms ? ST_SEL_IR   : ST_CAP_DR;
                ST_CAP_DR:   r_state <= tms ? ST_EXIT1_DR : ST_SHIFT_DR;
                ST_SHIFT_DR: r_state <= tms ? ST_EXIT1_DR : ST_SHIFT_DR;
                ST_EXIT1_DR: r_state <= tms ? ST_UPD_DR   : ST_PAUSE_DR;
                ST_PAUSE_DR: r_state <= tms ? ST_EXIT2_DR : ST_PAUSE_DR;
                ST_EXIT2_DR: r_state <= tms ? ST_UPD_DR   : ST_SHIFT_DR;
                ST_UPD_DR:   r_state <= tms ? ST_SEL_DR   : ST_RTI;
                ST_SEL_IR:   r_state <= tms ? ST_TLR      : ST_CAP_IR;
                ST_CAP_IR:   r_state <= tms ? ST_EXIT1_IR : ST_SHIFT_IR;
                ST_SHIFT_IR: r_state <= tms ? ST_EXIT1_IR : ST_SHIFT_IR;
                ST_EXIT1_IR: r_state <= tms ? ST_UPD_IR   : ST_PAUSE_IR;
                ST_PAUSE_IR: r_state <= tms ? ST_EXIT2_IR : ST_PAUSE_IR;
                ST_EXIT2_IR: r_state <= tms ? ST_UPD_IR   : ST_SHIFT_IR;
                ST_UPD_IR:   r_state <= tms ? ST_SEL_DR   : ST_RTI;
                default:     r_state <= ST_TLR;
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: rtl/jtag_multichain_tap.sv
// Multi-chain JTAG TAP: IR, BYPASS, optional IDCODE and N_CHAINS scan chain selects.
// Define TAP_IDCODE_EN to build the IDCODE register and make IDCODE the reset instruction.
module jtag_multichain_tap
    import jtag_pkg::*;
#(
    parameter int          N_CHAINS   = 4,
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo_pad_o,
    output logic                tdo_paden_o,
    input  logic [N_CHAINS-1:0] sout,
    output logic                sin,
    output logic [N_CHAINS-1:0] shift,
    output logic                test
);

    localparam tap_ops_t        OPS       = tap_ops(IR_W);
    localparam logic [IR_W-1:0] OP_BYPASS = OPS.bypass[IR_W-1:0];
`ifdef TAP_IDCODE_EN
    localparam logic [IR_W-1:0] OP_IDCODE = OPS.idcode[IR_W-1:0];
    localparam logic [IR_W-1:0] RESET_IR  = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] RESET_IR  = OP_BYPASS;
`endif

    tap_state_e          w_state;
    logic                w_shift_dr;
    logic                w_shift_ir;
    logic [N_CHAINS-1:0] w_chain_sel;
    logic                w_scan;
    logic                w_sel_idcode;
    logic                w_idcode_bit;
    logic                w_tdo_next;
    logic [IR_W-1:0]     r_ir_sr;
    logic [IR_W-1:0]     r_ir_active;
    logic                r_bypass;

    jtag_tap_fsm u_fsm (
        .tck   (tck),
        .trst  (trst),
        .tms   (tms),
        .state (w_state)
    );

    assign w_shift_dr = (w_state == ST_SHIFT_DR);
    assign w_shift_ir = (w_state == ST_SHIFT_IR);
    assign test       = (w_state != ST_TLR) && (w_state != ST_RTI);
    assign sin        = tdi;

    for (genvar k = 0; k < N_CHAINS; k++) begin : g_sel
        assign w_chain_sel[k] = (r_ir_active == IR_W'(k));
    end

    // Decoded from the registered state, so trst drops every enable at once.
    assign shift  = w_shift_dr ? w_chain_sel : '0;
    assign w_scan = |w_chain_sel;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_ir_sr <= '0;
        end else if (w_state == ST_TLR) begin
            r_ir_sr <= '0;
        end else if (w_state == ST_CAP_IR) begin
            r_ir_sr <= IR_W'(IR_CAPTURE);
        end else if (w_shift_ir) begin
            r_ir_sr <= {tdi, r_ir_sr[IR_W-1:1]};
        end
    end

    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            r_ir_active <= RESET_IR;
        end else if (w_state == ST_TLR) begin
            r_ir_active <= RESET_IR;
        end else if (w_state == ST_UPD_IR) begin
            r_ir_active <= r_ir_sr;
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_bypass <= 1'b0;
        end else if (w_state == ST_TLR || w_state == ST_CAP_DR) begin
            r_bypass <= 1'b0;
        end else if (w_shift_dr) begin
            r_bypass <= tdi;
        end
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] r_idcode;

    assign w_sel_idcode = (r_ir_active == OP_IDCODE);
    assign w_idcode_bit = r_idcode[0];

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_idcode <= IDCODE_VAL;
        end else if (w_state == ST_TLR || w_state == ST_CAP_DR) begin
            r_idcode <= IDCODE_VAL;
        end else if (w_shift_dr && w_sel_idcode) begin
            r_idcode <= {tdi, r_idcode[31:1]};
        end
    end
`else
    assign w_sel_idcode = 1'b0;
    assign w_idcode_bit = 1'b0;
`endif

    always_comb begin
        w_tdo_next = 1'b0;
        if (w_shift_ir) begin
            w_tdo_next = r_ir_sr[0];
        end else if (w_shift_dr) begin
            if (w_scan)            w_tdo_next = |(w_chain_sel & sout);
            else if (w_sel_idcode) w_tdo_next = w_idcode_bit;
            else                   w_tdo_next = r_bypass;
        end
    end

    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo_pad_o   <= 1'b0;
            tdo_paden_o <= 1'b1;
        end else begin
            tdo_pad_o   <= w_tdo_next;
            tdo_paden_o <= !(w_shift_ir || w_shift_dr);
        end
    end

endmodule
